// File: rtl/gf163_reduce_seq.sv
// gf163_reduce_seq
//   Sequential reduction of a 325-bit carry-less product modulo
//   f(x) = x^163 + x^7 + x^6 + x^3 + 1. The block takes the unreduced product
//   over a valid/ready handshake and folds it in two registered passes. It
//   holds the 163-bit field element until the consumer takes it.
//
// Ports
//   clk        rising-edge clock
//   rst        asynchronous, active-high reset
//   c          unreduced product, c[i] = coefficient of x^i
//   in_valid   c is valid
//   in_ready   block can accept c (state == IDLE)
//   y          reduced result c mod f (registered)
//   out_valid  y is valid (registered)
//   out_ready  consumer accepts y
module gf163_reduce_seq (
   input  logic         clk,
   input  logic         rst,
   input  logic [324:0] c,
   input  logic         in_valid,
   output logic         in_ready,
   output logic [162:0] y,
   output logic         out_valid,
   input  logic         out_ready
);

   typedef enum logic [1:0] {IDLE, FOLD1, FOLD2, DONE} state_t;

   state_t       state, state_next;
   logic [324:0] c_reg;
   logic [168:0] t_reg;
   logic [161:0] h;
   logic [5:0]   h2;
   logic [168:0] t_next;
   logic [162:0] y_next;

   // Fold datapath. Because x^163 == x^7 + x^6 + x^3 + 1, each high term
   // maps onto four low terms. The first fold leaves at most 6 bits above
   // x^162. The second fold lands at degree <= 12, so it is exact.
   always_comb begin
      h      = c_reg[324:163];
      t_next = {6'b0, c_reg[162:0]}
             ^ {7'b0, h}
             ^ {4'b0, h, 3'b0}
             ^ {1'b0, h, 6'b0}
             ^ {h, 7'b0};
      h2     = t_reg[168:163];
      y_next = t_reg[162:0]
             ^ {157'b0, h2}
             ^ {154'b0, h2, 3'b0}
             ^ {151'b0, h2, 6'b0}
             ^ {150'b0, h2, 7'b0};
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) state <= IDLE;
      else     state <= state_next;
   end

   always_comb begin
      state_next = state;
      in_ready   = 1'b0;
      case (state)
         IDLE: begin
            in_ready = 1'b1;
            if (in_valid) state_next = FOLD1;
         end
         FOLD1:   state_next = FOLD2;
         FOLD2:   state_next = DONE;
         DONE:    if (out_ready) state_next = IDLE;
         default: state_next = IDLE;
      endcase
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         c_reg     <= '0;
         t_reg     <= '0;
         y         <= '0;
         out_valid <= 1'b0;
      end else begin
         if (state == IDLE && in_valid) c_reg <= c;
         if (state == FOLD1) t_reg <= t_next;
         if (state == FOLD2) begin
            y         <= y_next;
            out_valid <= 1'b1;
         end else if (state == DONE && out_ready) begin
            out_valid <= 1'b0;
         end
      end
   end

endmodule

// File: tb/tb_gf163_reduce_seq.sv
// tb_gf163_reduce_seq
//   Testbench for gf163_reduce_seq. Expected results come from a
//   polynomial long-division model of c mod f.
module tb_gf163_reduce_seq;

   logic         clk;
   logic         rst;
   logic [324:0] c;
   logic         in_valid;
   logic         in_ready;
   logic [162:0] y;
   logic         out_valid;
   logic         out_ready;

   int passed = 0;
   int total  = 0;

   gf163_reduce_seq dut (
      .clk       (clk),
      .rst       (rst),
      .c         (c),
      .in_valid  (in_valid),
      .in_ready  (in_ready),
      .y         (y),
      .out_valid (out_valid),
      .out_ready (out_ready)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   initial begin
      #1000000;
      $display("FAIL watchdog: time limit reached, got no finish, want finish");
      $fatal(1, "simulation time limit");
   end

   // Long division by f: cancel every bit at degree >= 163, top down.
   function automatic logic [162:0] ref_mod(input logic [324:0] a);
      logic [324:0] r;
      logic [324:0] f;
      r = a;
      f = '0;
      f[163] = 1'b1; f[7] = 1'b1; f[6] = 1'b1; f[3] = 1'b1; f[0] = 1'b1;
      for (int i = 324; i >= 163; i--)
         if (r[i]) r = r ^ (f << (i - 163));
      return r[162:0];
   endfunction

   function automatic logic [324:0] rand_vec();
      logic [324:0] r;
      r = '0;
      for (int i = 0; i < 11; i++) r = (r << 32) | 325'($urandom);
      return r;
   endfunction

   // Present cv, wait for acceptance, then count cycles until out_valid.
   // lat = -1 means the block never became ready.
   task automatic do_txn(input logic [324:0] cv, output logic [162:0] yv, output int lat);
      int w;
      @(negedge clk);
      c = cv;
      in_valid = 1'b1;
      w = 0;
      while (!in_ready && w < 20) begin @(negedge clk); w++; end
      if (!in_ready) begin
         in_valid = 1'b0;
         lat = -1;
         yv = '0;
         return;
      end
      @(posedge clk); #1;
      in_valid = 1'b0;
      lat = 0;
      while (!out_valid && lat < 10) begin @(posedge clk); #1; lat++; end
      yv = y;
   endtask

   task automatic release_out();
      @(negedge clk);
      out_ready = 1'b1;
      @(posedge clk); #1;
      out_ready = 1'b0;
   endtask

   task automatic test_reset();
      logic spurious;
      rst = 1'b1; in_valid = 1'b0; out_ready = 1'b0; c = '0;
      #2;
      total++; if (y !== 163'd0) $display("FAIL reset_y: got %h want 0", y); else passed++;
      total++; if (out_valid !== 1'b0) $display("FAIL reset_out_valid: got %b want 0", out_valid); else passed++;
      total++; if (in_ready !== 1'b1) $display("FAIL reset_in_ready: got %b want 1", in_ready); else passed++;
      @(negedge clk); rst = 1'b0;
      // d = 0/1/2 extra edges puts the block in FOLD1/FOLD2/DONE.
      for (int d = 0; d < 3; d++) begin
         @(negedge clk);
         c = rand_vec();
         in_valid = 1'b1;
         @(posedge clk); #1;
         in_valid = 1'b0;
         for (int k = 0; k < d; k++) begin @(posedge clk); #1; end
         rst = 1'b1;
         #1;
         total++; if (y !== 163'd0) $display("FAIL reset_mid%0d_y: got %h want 0", d, y); else passed++;
         total++; if (out_valid !== 1'b0) $display("FAIL reset_mid%0d_out_valid: got %b want 0", d, out_valid); else passed++;
         total++; if (in_ready !== 1'b1) $display("FAIL reset_mid%0d_in_ready: got %b want 1", d, in_ready); else passed++;
         @(negedge clk); rst = 1'b0;
         spurious = 1'b0;
         for (int k = 0; k < 5; k++) begin
            @(posedge clk); #1;
            if (out_valid !== 1'b0) spurious = 1'b1;
         end
         total++; if (spurious !== 1'b0) $display("FAIL reset_mid%0d_spurious: got out_valid 1 want 0", d); else passed++;
      end
   endtask

   task automatic test_single_bit();
      logic [324:0] v;
      logic [162:0] yv;
      int lat;
      v = '0; v[163] = 1'b1;
      do_txn(v, yv, lat);
      total++; if (lat !== 2) $display("FAIL single_bit_latency: got %0d want 2", lat); else passed++;
      total++; if (yv !== 163'hC9) $display("FAIL single_bit_y: got %h want c9", yv); else passed++;
      release_out();
   endtask

   task automatic test_top_bit();
      logic [324:0] v;
      logic [162:0] yv, exp;
      int lat;
      v = '0; v[324] = 1'b1;
      exp = (163'd1 << 161) | 163'h1422;
      do_txn(v, yv, lat);
      total++; if (lat !== 2) $display("FAIL top_bit_latency: got %0d want 2", lat); else passed++;
      total++; if (yv !== exp) $display("FAIL top_bit_y: got %h want %h", yv, exp); else passed++;
      release_out();
   endtask

   task automatic test_passthrough_zero();
      logic [324:0] v;
      logic [162:0] yv;
      int lat;
      v = '0; v[162:0] = '1;
      do_txn(v, yv, lat);
      total++; if (yv !== {163{1'b1}}) $display("FAIL passthrough_y: got %h want all ones", yv); else passed++;
      release_out();
      do_txn('0, yv, lat);
      total++; if (lat !== 2) $display("FAIL zero_latency: got %0d want 2", lat); else passed++;
      total++; if (yv !== 163'd0) $display("FAIL zero_y: got %h want 0", yv); else passed++;
      release_out();
   endtask

   task automatic test_backpressure();
      logic [324:0] a, b, d;
      logic [162:0] yv, ea;
      logic bad_y, bad_v, bad_r;
      int lat;
      a = rand_vec(); b = rand_vec(); d = rand_vec();
      ea = ref_mod(a);
      out_ready = 1'b0;
      do_txn(a, yv, lat);
      total++; if (yv !== ea) $display("FAIL backpressure_first_y: got %h want %h", yv, ea); else passed++;
      bad_y = 1'b0; bad_v = 1'b0; bad_r = 1'b0;
      for (int i = 0; i < 5; i++) begin
         @(negedge clk);
         c = b;
         in_valid = (i % 2 == 0);
         if (y !== ea) bad_y = 1'b1;
         if (out_valid !== 1'b1) bad_v = 1'b1;
         if (in_ready !== 1'b0) bad_r = 1'b1;
      end
      @(negedge clk); in_valid = 1'b0;
      total++; if (bad_y) $display("FAIL backpressure_y_stable: got changed y want %h", ea); else passed++;
      total++; if (bad_v) $display("FAIL backpressure_out_valid: got 0 want 1"); else passed++;
      total++; if (bad_r) $display("FAIL backpressure_in_ready: got 1 want 0"); else passed++;
      release_out();
      total++; if (out_valid !== 1'b0) $display("FAIL backpressure_release_valid: got %b want 0", out_valid); else passed++;
      total++; if (in_ready !== 1'b1) $display("FAIL backpressure_release_ready: got %b want 1", in_ready); else passed++;
      do_txn(d, yv, lat);
      total++; if (yv !== ref_mod(d)) $display("FAIL backpressure_next_y: got %h want %h", yv, ref_mod(d)); else passed++;
      release_out();
   endtask

   task automatic test_stream(input bit rand_ready);
      logic [162:0] expq[$];
      logic [324:0] vecs[100];
      for (int i = 0; i < 100; i++) vecs[i] = rand_vec();
      out_ready = rand_ready ? 1'b0 : 1'b1;
      fork
         begin
            int w;
            for (int i = 0; i < 100; i++) begin
               @(negedge clk);
               c = vecs[i];
               in_valid = 1'b1;
               w = 0;
               while (!in_ready && w < 50) begin @(negedge clk); w++; end
               if (!in_ready) begin
                  total++;
                  $display("FAIL stream%0d_accept_timeout: got no in_ready want in_ready at vector %0d", rand_ready, i);
                  break;
               end
               expq.push_back(ref_mod(vecs[i]));
               @(posedge clk);
            end
            @(negedge clk);
            in_valid = 1'b0;
         end
         begin
            int got, cyc, last_cyc;
            got = 0; cyc = 0; last_cyc = 0;
            while (got < 100 && cyc < 5000) begin
               @(negedge clk);
               cyc++;
               if (rand_ready) out_ready = 1'($urandom_range(0, 1));
               if (out_valid && out_ready) begin
                  total++;
                  if (expq.size() == 0)
                     $display("FAIL stream%0d_y[%0d]: got %h want nothing", rand_ready, got, y);
                  else if (y !== expq[0])
                     $display("FAIL stream%0d_y[%0d]: got %h want %h", rand_ready, got, y, expq[0]);
                  else
                     passed++;
                  if (expq.size() != 0) void'(expq.pop_front());
                  if (!rand_ready && got > 0) begin
                     total++;
                     if (cyc - last_cyc != 4)
                        $display("FAIL stream_spacing[%0d]: got %0d cycles want 4", got, cyc - last_cyc);
                     else
                        passed++;
                  end
                  last_cyc = cyc;
                  got++;
               end
            end
            total++;
            if (got != 100) $display("FAIL stream%0d_count: got %0d want 100", rand_ready, got); else passed++;
         end
      join
      @(negedge clk);
      out_ready = 1'b0;
   endtask

   initial begin
      test_reset();
      test_single_bit();
      test_top_bit();
      test_passthrough_zero();
      test_backpressure();
      test_stream(1'b0);
      test_stream(1'b1);
      repeat (4) @(posedge clk);
      $display("%0d/%0d checks passed", passed, total);
      $finish;
   end

endmodule
